// File: rtl/regfile_pkg.sv
// regfile_pkg: shared write-mode encoding, a0 index and write-merge function for regfile_sb
package regfile_pkg;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_WORD = 2'b01,
        WR_HALF = 2'b10,
        WR_BYTE = 2'b11
    } wr_mode_t;

    localparam int REG_A0 = 10;
    localparam int MERGE_W = 128;

    // Callers widen to MERGE_W and truncate back, so one function serves any DATA_WIDTH up to MERGE_W
    function automatic logic [MERGE_W-1:0] merge_write(input logic [MERGE_W-1:0] old_v, input logic [MERGE_W-1:0] new_v, input wr_mode_t mode);
        return mode == WR_WORD ? new_v :
               mode == WR_HALF ? {old_v[MERGE_W-1:16], new_v[15:0]} :
               mode == WR_BYTE ? {old_v[MERGE_W-1:8], new_v[7:0]} : old_v;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits; a same-edge set overrides a clear
module regfile_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS = 2**REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_en,
    input  logic [REG_ADDR_WIDTH-1:0] set_idx,
    input  logic                      clr_en,
    input  logic [REG_ADDR_WIDTH-1:0] clr_idx,
    output logic [NUM_REGS-1:0]       busy
);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_idx] <= 1'b0;
            if (set_en) busy[set_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with x0, partial-write merge and busy scoreboard; REGFILE_BYPASS_EN enables same-cycle forwarding
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_READ = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_READ*REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]     rd_data,
    output logic [NUM_READ-1:0]                rd_busy,
    input  logic [1:0]                         wr_mode,
    input  logic [REG_ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic                               issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]          issue_rd,
    output logic [DATA_WIDTH-1:0]              a0
);

    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic                  wr_en;
    logic                  issue_en;
    logic [DATA_WIDTH-1:0] wr_merged;

    assign wr_en = wr_mode_t'(wr_mode) != WR_NONE && wr_addr != '0;
    assign issue_en = issue_valid && issue_rd != '0;
    assign wr_merged = DATA_WIDTH'(merge_write(MERGE_W'(regs[wr_addr]), MERGE_W'(wr_data), wr_mode_t'(wr_mode)));
    assign a0 = regs[REG_ADDR_WIDTH'(REG_A0)];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_merged;
        end
    end

    regfile_scoreboard #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .NUM_REGS(NUM_REGS)
    ) u_scoreboard (
        .clk(clk),
        .rst(rst),
        .set_en(issue_en),
        .set_idx(issue_rd),
        .clr_en(wr_en),
        .clr_idx(wr_addr),
        .busy(busy)
    );

    genvar i;
    generate
        for (i = 0; i < NUM_READ; i++) begin : g_rd
            logic [REG_ADDR_WIDTH-1:0] ra;
            logic                      fwd;
            assign ra = rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
            assign fwd = wr_en && wr_addr == ra;
`else
            assign fwd = 1'b0;
`endif
            assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = ra == '0 ? '0 : fwd ? wr_merged : regs[ra];
            // A forwarded write retires the pending load unless a new issue re-claims the register
            assign rd_busy[i] = ra != '0 && busy[ra] && !(fwd && !(issue_en && issue_rd == ra));
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed checks of regfile_sb against an array/flag reference model (honours REGFILE_BYPASS_EN)
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_mode = 2'b00;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] a0;

    logic [31:0] m_regs [32];
    logic        m_busy [32];
    int total = 0;
    int passed = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_sb dut (
        .clk(clk),
        .rst(rst),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_busy(rd_busy),
        .wr_mode(wr_mode),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .a0(a0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merged(input logic [31:0] old_v, input logic [31:0] new_v, input logic [1:0] mode);
        case (mode)
            2'd1: return new_v;
            2'd2: return (old_v & 32'hFFFF_0000) | (new_v & 32'h0000_FFFF);
            2'd3: return (old_v & 32'hFFFF_FF00) | (new_v & 32'h0000_00FF);
            default: return old_v;
        endcase
    endfunction

    function automatic logic writes(input logic [4:0] a);
        return wr_mode != 2'd0 && wr_addr == a && a != 5'd0;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYPASS && writes(a)) return merged(m_regs[a], wr_data, wr_mode);
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0 || !m_busy[a]) return 1'b0;
        if (BYPASS && writes(a) && !(issue_valid && issue_rd == a)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (writes(wr_addr)) begin
                m_regs[wr_addr] = merged(m_regs[wr_addr], wr_data, wr_mode);
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        wr_mode = 2'd0;
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_mode = 2'd1; wr_addr = 5'd3; wr_data = 32'h1234_5678;
        issue_valid = 1'b1; issue_rd = 5'd4;
        cyc();
        idle();
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            total++;
            if (rd_data !== 64'd0 || rd_busy !== 2'b00)
                $display("FAIL reset_read x%0d: got data=%h busy=%b exp data=0 busy=00", a, rd_data, rd_busy);
            else passed++;
        end
        total++;
        if (a0 !== 32'd0) $display("FAIL reset_a0: got %h exp 0", a0);
        else passed++;
    endtask

    task automatic test_merge();
        logic [31:0] seq_data [3];
        logic [1:0]  seq_mode [3];
        logic [31:0] seq_exp [3];
        seq_data = '{32'hDEADBEEF, 32'h0000_1234, 32'h0000_0056};
        seq_mode = '{2'd1, 2'd2, 2'd3};
        seq_exp = '{32'hDEADBEEF, 32'hDEAD1234, 32'hDEAD1256};
        for (int k = 0; k < 3; k++) begin
            wr_mode = seq_mode[k]; wr_addr = 5'd10; wr_data = seq_data[k];
            cyc();
            idle();
            rd_addr = {5'd10, 5'd10};
            #1;
            total++;
            if (a0 !== seq_exp[k] || rd_data[31:0] !== seq_exp[k])
                $display("FAIL merge_%0d: got a0=%h rd=%h exp %h", k, a0, rd_data[31:0], seq_exp[k]);
            else passed++;
        end
    endtask

    task automatic test_x0();
        wr_mode = 2'd1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #1;
        total++;
        if (rd_data !== 64'd0 || rd_busy !== 2'b00) $display("FAIL x0_same_cycle: got %h/%b exp 0/00", rd_data, rd_busy);
        else passed++;
        cyc();
        idle();
        #1;
        total++;
        if (rd_data !== 64'd0 || rd_busy !== 2'b00) $display("FAIL x0_after: got %h/%b exp 0/00", rd_data, rd_busy);
        else passed++;
    endtask

    task automatic test_forward();
        wr_mode = 2'd1; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5;
        rd_addr = {5'd5, 5'd10};
        #1;
        total++;
        if (rd_data[63:32] !== (BYPASS ? 32'hA5A5A5A5 : 32'd0) || a0 !== 32'hDEAD1256)
            $display("FAIL fwd_word: got rd1=%h a0=%h exp rd1=%h a0=DEAD1256", rd_data[63:32], a0, BYPASS ? 32'hA5A5A5A5 : 32'd0);
        else passed++;
        cyc();
        idle();
        #1;
        total++;
        if (rd_data[63:32] !== 32'hA5A5A5A5) $display("FAIL fwd_next: got %h exp A5A5A5A5", rd_data[63:32]);
        else passed++;
        wr_mode = 2'd2; wr_addr = 5'd5; wr_data = 32'h7777_1111;
        rd_addr = {5'd5, 5'd5};
        #1;
        total++;
        if (rd_data !== {2{BYPASS ? 32'hA5A51111 : 32'hA5A5A5A5}})
            $display("FAIL fwd_half: got %h exp %h", rd_data, {2{BYPASS ? 32'hA5A51111 : 32'hA5A5A5A5}});
        else passed++;
        cyc();
        idle();
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd7, 5'd7};
        issue_valid = 1'b1; issue_rd = 5'd7;
        cyc();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (rd_busy !== 2'b11) $display("FAIL busy_hold_%0d: got %b exp 11", k, rd_busy);
            else passed++;
            cyc();
        end
        wr_mode = 2'd1; wr_addr = 5'd7; wr_data = 32'h0BAD_F00D;
        #1;
        total++;
        if (rd_busy !== (BYPASS ? 2'b00 : 2'b11)) $display("FAIL busy_write_cycle: got %b exp %b", rd_busy, BYPASS ? 2'b00 : 2'b11);
        else passed++;
        cyc();
        idle();
        #1;
        total++;
        if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h0BAD_F00D) $display("FAIL busy_cleared: got %b/%h exp 00/0BADF00D", rd_busy, rd_data[31:0]);
        else passed++;
        issue_valid = 1'b1; issue_rd = 5'd7;
        wr_mode = 2'd3; wr_addr = 5'd7; wr_data = 32'h0000_00EE;
        cyc();
        idle();
        #1;
        total++;
        if (rd_busy !== 2'b11 || rd_data[31:0] !== 32'h0BAD_F0EE) $display("FAIL issue_wins: got %b/%h exp 11/0BADF0EE", rd_busy, rd_data[31:0]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        wr_mode = 2'd1; wr_addr = 5'd3; wr_data = 32'h55;
        cyc();
        idle();
        rd_addr = {5'd3, 5'd7};
        #1;
        total++;
        if (rd_data[31:0] !== 32'h7 && rd_data[63:32] !== 32'h55 && rd_busy !== 2'b10) begin end
        if (rd_data[63:32] !== 32'h55 || rd_busy !== 2'b01) $display("FAIL pre_reset: got %h/%b exp 55/01", rd_data[63:32], rd_busy);
        else passed++;
        rst = 1'b1;
        wr_mode = 2'd1; wr_addr = 5'd4; wr_data = 32'hCAFE;
        issue_valid = 1'b1; issue_rd = 5'd9;
        cyc();
        idle();
        #1;
        total++;
        if (rd_data[63:32] !== 32'd0 || rd_busy !== 2'b00) $display("FAIL mid_reset: got x3=%h busy=%b exp 0/00", rd_data[63:32], rd_busy);
        else passed++;
        rd_addr = {5'd4, 5'd9};
        #1;
        total++;
        if (rd_data[63:32] !== 32'd0 || rd_busy !== 2'b00) $display("FAIL reset_discard: got x4=%h busy=%b exp 0/00", rd_data[63:32], rd_busy);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = $urandom_range(0, 49) == 0;
            wr_mode = 2'($urandom);
            wr_addr = 5'($urandom_range(0, 11));
            wr_data = $urandom;
            issue_valid = $urandom_range(0, 2) == 0;
            issue_rd = 5'($urandom_range(0, 11));
            rd_addr = {5'($urandom_range(0, 11)), $urandom_range(0, 3) == 0 ? wr_addr : 5'($urandom_range(0, 11))};
            #1;
            for (int p = 0; p < 2; p++) begin
                logic [4:0] ra;
                ra = rd_addr[p*5 +: 5];
                total++;
                if (rd_data[p*32 +: 32] !== exp_data(ra) || rd_busy[p] !== exp_busy(ra))
                    $display("FAIL rand_port%0d n=%0d x%0d: got %h/%b exp %h/%b", p, n, ra, rd_data[p*32 +: 32], rd_busy[p], exp_data(ra), exp_busy(ra));
                else passed++;
            end
            total++;
            if (a0 !== m_regs[10]) $display("FAIL rand_a0 n=%0d: got %h exp %h", n, a0, m_regs[10]);
            else passed++;
            cyc();
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_merge();
        test_x0();
        test_forward();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
